// File: rtl/tdp_ram_pkg.sv
// ---------------------------------------------------------------------------
// tdp_ram_pkg
// Shared definitions for the true dual-port byte-enable RAM:
//   - read-during-write mode codes (MODE_NO_CHANGE / MODE_READ_FIRST /
//     MODE_WRITE_FIRST)
//   - init sweep FSM state enum
//   - byte_merge(): lane-wise merge of new data over an old word, used by
//     the memory write path and by the WRITE_FIRST read data path
// Optional feature macro used by the RAM top: TDP_RAM_COLLISION_DET_EN
// ---------------------------------------------------------------------------
package tdp_ram_pkg;

  localparam int MODE_NO_CHANGE   = 0;
  localparam int MODE_READ_FIRST  = 1;
  localparam int MODE_WRITE_FIRST = 2;

  // byte_merge works on vectors of a fixed maximum size so that one package
  // function can serve any WIDTH/BYTE_W instance; callers zero-extend their
  // operands and truncate the result back to their own width.
  localparam int MERGE_MAX_W  = 256;
  localparam int MERGE_MAX_NB = 32;
  localparam int MERGE_LANE_W = 5;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_DONE  = 1'b1
  } init_state_t;

  // Every bit takes new_word where its byte lane enable is set and keeps
  // old_word otherwise. byte_w is always a constant at the call site, so the
  // division folds away to fixed wiring.
  function automatic logic [MERGE_MAX_W-1:0] byte_merge(
    input logic [MERGE_MAX_W-1:0]  old_word,
    input logic [MERGE_MAX_W-1:0]  new_word,
    input logic [MERGE_MAX_NB-1:0] we,
    input int                      byte_w
  );
    logic [MERGE_MAX_W-1:0] res;
    int lane;
    res = old_word;
    for (int b = 0; b < MERGE_MAX_W; b++) begin
      lane = b / byte_w;
      if (lane < MERGE_MAX_NB && we[lane[MERGE_LANE_W-1:0]]) begin
        res[b] = new_word[b];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/tdp_ram_out_pipe.sv
// ---------------------------------------------------------------------------
// tdp_ram_out_pipe
// Optional output register stage for one RAM port.
//   OUT_REG = 1 : data/valid delayed by one clock, cleared by reset
//   OUT_REG = 0 : straight wires
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   i_data, i_valid   stage-1 read data and valid
//   o_data, o_valid   port read data and valid
// ---------------------------------------------------------------------------
module tdp_ram_out_pipe #(
  parameter int WIDTH   = 32,
  parameter int OUT_REG = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid
);

  generate
    if (OUT_REG != 0) begin : g_reg
      logic [WIDTH-1:0] r_data;
      logic             r_valid;

      // Plain copy of stage 1; data simply follows so a held stage-1 value
      // stays held here too.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_data  <= '0;
          r_valid <= 1'b0;
        end else begin
          r_data  <= i_data;
          r_valid <= i_valid;
        end
      end

      assign o_data  = r_data;
      assign o_valid = r_valid;
    end else begin : g_bypass
      assign o_data  = i_data;
      assign o_valid = i_valid;
    end
  endgenerate

endmodule

// File: rtl/true_dual_port_be_ram.sv
// ---------------------------------------------------------------------------
// true_dual_port_be_ram
// Single-clock true dual-port RAM with per-byte write enables, per-port
// read-during-write mode, optional output register and a zero-fill sweep
// after reset.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   init_done             zero-fill finished, port accesses accepted
//   ena/enb               port enable
//   wea/web               byte write enables (all zero = read)
//   addra/addrb           word address
//   dina/dinb             write data
//   douta/doutb           read data, latency 1 + OUT_REG
//   valida/validb         douta/doutb carry fresh data this cycle
//   collision             same-address conflict flag, present only when
//                         TDP_RAM_COLLISION_DET_EN is defined
// ---------------------------------------------------------------------------
module true_dual_port_be_ram
  import tdp_ram_pkg::*;
#(
  parameter int    WIDTH      = 32,
  parameter int    BYTE_W     = 8,
  parameter int    DEPTH      = 256,
  parameter string MODE_A     = "READ_FIRST",
  parameter string MODE_B     = "READ_FIRST",
  parameter int    OUT_REG    = 1,
  parameter int    INIT_CLEAR = 1,
  localparam int   NBYTE      = WIDTH / BYTE_W,
  localparam int   AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             init_done,
  input  logic             ena,
  input  logic [NBYTE-1:0] wea,
  input  logic [AW-1:0]    addra,
  input  logic [WIDTH-1:0] dina,
  output logic [WIDTH-1:0] douta,
  output logic             valida,
  input  logic             enb,
  input  logic [NBYTE-1:0] web,
  input  logic [AW-1:0]    addrb,
  input  logic [WIDTH-1:0] dinb,
  output logic [WIDTH-1:0] doutb,
  output logic             validb
`ifdef TDP_RAM_COLLISION_DET_EN
  ,
  output logic             collision
`endif
);

  localparam int MODE_A_C = (MODE_A == "NO_CHANGE")   ? MODE_NO_CHANGE :
                            (MODE_A == "WRITE_FIRST") ? MODE_WRITE_FIRST : MODE_READ_FIRST;
  localparam int MODE_B_C = (MODE_B == "NO_CHANGE")   ? MODE_NO_CHANGE :
                            (MODE_B == "WRITE_FIRST") ? MODE_WRITE_FIRST : MODE_READ_FIRST;

  function automatic logic [WIDTH-1:0] merge_word(
    input logic [WIDTH-1:0] old_word,
    input logic [WIDTH-1:0] new_word,
    input logic [NBYTE-1:0] we
  );
    return WIDTH'(byte_merge(MERGE_MAX_W'(old_word), MERGE_MAX_W'(new_word),
                             MERGE_MAX_NB'(we), BYTE_W));
  endfunction

  logic [WIDTH-1:0] r_mem [DEPTH];

  init_state_t      r_state, w_state_nxt;
  logic [AW-1:0]    r_ctr, w_ctr_nxt;
  logic             w_init_done, w_clearing;

  logic             w_acc_a, w_acc_b, w_wr_a, w_wr_b, w_same;
  logic             w_upd_a, w_upd_b;
  logic [WIDTH-1:0] w_old_a, w_old_b, w_mrg_a, w_mrg_b, w_mrg_ab;
  logic [WIDTH-1:0] w_data_a, w_data_b;
  logic [WIDTH-1:0] r_dout_a, r_dout_b;
  logic             r_valid_a, r_valid_b;

  // Init sweep state register. Without INIT_CLEAR the RAM comes out of
  // reset already usable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= (INIT_CLEAR != 0) ? ST_CLEAR : ST_DONE;
      r_ctr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ctr   <= w_ctr_nxt;
    end
  end

  // One word cleared per cycle; leaving CLEAR on the edge that writes the
  // last word makes init_done rise exactly DEPTH edges after reset release.
  always_comb begin
    w_state_nxt = r_state;
    w_ctr_nxt   = r_ctr;
    if (r_state == ST_CLEAR) begin
      w_ctr_nxt = r_ctr + AW'(1);
      if (r_ctr == AW'(DEPTH - 1)) begin
        w_state_nxt = ST_DONE;
      end
    end
  end

  assign w_init_done = (r_state == ST_DONE);
  assign w_clearing  = (r_state == ST_CLEAR);
  assign init_done   = w_init_done;

  // Accesses are ignored entirely until the sweep has finished.
  assign w_acc_a = ena & w_init_done;
  assign w_acc_b = enb & w_init_done;
  assign w_wr_a  = w_acc_a & (|wea);
  assign w_wr_b  = w_acc_b & (|web);
  assign w_same  = (addra == addrb);

  assign w_old_a  = r_mem[addra];
  assign w_old_b  = r_mem[addrb];
  assign w_mrg_a  = merge_word(w_old_a, dina, wea);
  assign w_mrg_b  = merge_word(w_old_b, dinb, web);
  // Same-address double write: B's lanes go in first, A's lanes on top, so
  // A wins only where both enable the same lane.
  assign w_mrg_ab = merge_word(w_mrg_b, dina, wea);

  // All memory writes live here so port priority is decided in one place.
  always_ff @(posedge clk) begin
    if (w_clearing) begin
      r_mem[r_ctr] <= '0;
    end else if (w_wr_a && w_wr_b && w_same) begin
      r_mem[addra] <= w_mrg_ab;
    end else begin
      if (w_wr_b) r_mem[addrb] <= w_mrg_b;
      if (w_wr_a) r_mem[addra] <= w_mrg_a;
    end
  end

  // Stage-1 data selection. The merged word only ever uses the port's own
  // din, so a reading port always sees pre-write data even when the other
  // port writes the same word.
  assign w_upd_a  = w_acc_a & ((MODE_A_C != MODE_NO_CHANGE) | ~(|wea));
  assign w_upd_b  = w_acc_b & ((MODE_B_C != MODE_NO_CHANGE) | ~(|web));
  assign w_data_a = (MODE_A_C == MODE_WRITE_FIRST) ? w_mrg_a : w_old_a;
  assign w_data_b = (MODE_B_C == MODE_WRITE_FIRST) ? w_mrg_b : w_old_b;

  // Stage-1 output registers; dout holds its last value when not updated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout_a  <= '0;
      r_dout_b  <= '0;
      r_valid_a <= 1'b0;
      r_valid_b <= 1'b0;
    end else begin
      r_valid_a <= w_upd_a;
      r_valid_b <= w_upd_b;
      if (w_upd_a) r_dout_a <= w_data_a;
      if (w_upd_b) r_dout_b <= w_data_b;
    end
  end

  tdp_ram_out_pipe #(.WIDTH(WIDTH), .OUT_REG(OUT_REG)) u_pipe_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_data  (r_dout_a),
    .i_valid (r_valid_a),
    .o_data  (douta),
    .o_valid (valida)
  );

  tdp_ram_out_pipe #(.WIDTH(WIDTH), .OUT_REG(OUT_REG)) u_pipe_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_data  (r_dout_b),
    .i_valid (r_valid_b),
    .o_data  (doutb),
    .o_valid (validb)
  );

`ifdef TDP_RAM_COLLISION_DET_EN
  logic r_collision;

  // Flag aligned with stage 1, independent of the output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_collision <= 1'b0;
    end else begin
      r_collision <= w_acc_a & w_acc_b & w_same & ((|wea) | (|web));
    end
  end

  assign collision = r_collision;
`endif

endmodule

// File: tb/tb_true_dual_port_be_ram.sv
// ---------------------------------------------------------------------------
// tb_true_dual_port_be_ram
// Drives two RAM instances with identical stimulus:
//   dut0 : default build (READ_FIRST on both ports, OUT_REG=1)
//   dut1 : MODE_A=WRITE_FIRST, MODE_B=NO_CHANGE, OUT_REG=0
// Expected read data comes from a word-array model of the memory and is
// queued per port with its due cycle; a negedge monitor pops and compares.
// ---------------------------------------------------------------------------
module tb_true_dual_port_be_ram;

  localparam int D = 256;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena, enb;
  logic [3:0]  wea, web;
  logic [7:0]  addra, addrb;
  logic [31:0] dina, dinb;
  logic [31:0] douta0, doutb0, douta1, doutb1;
  logic        valida0, validb0, valida1, validb1;
  logic        init0, init1;
`ifdef TDP_RAM_COLLISION_DET_EN
  logic        coll0, coll1;
`endif

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int nTests = 0;
  int nFail  = 0;

  typedef struct {
    int          due;
    logic [31:0] data;
  } exp_t;

  exp_t        expQ[4][$];
  logic [31:0] lastData[4];
  logic [31:0] modelMem[D];
  bit          collExp[int];

  true_dual_port_be_ram dut0 (
    .clk(clk), .rst_n(rst_n), .init_done(init0),
    .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta0), .valida(valida0),
    .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb0), .validb(validb0)
`ifdef TDP_RAM_COLLISION_DET_EN
    , .collision(coll0)
`endif
  );

  true_dual_port_be_ram #(.MODE_A("WRITE_FIRST"), .MODE_B("NO_CHANGE"), .OUT_REG(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .init_done(init1),
    .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta1), .valida(valida1),
    .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb1), .validb(validb1)
`ifdef TDP_RAM_COLLISION_DET_EN
    , .collision(coll1)
`endif
  );

  function automatic logic [31:0] laneMerge(input logic [31:0] oldW, input logic [31:0] newW,
                                            input logic [3:0] we);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) res[i*8 +: 8] = we[i] ? newW[i*8 +: 8] : oldW[i*8 +: 8];
    return res;
  endfunction

  task automatic checkEq(input string name, input logic [31:0] got, input logic [31:0] want);
    nTests++;
    if (got !== want) begin
      nFail++;
      $display("[TB] FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  // Port p: 0=dut0 A, 1=dut0 B, 2=dut1 A, 3=dut1 B
  task automatic checkOutput(input int p, input logic v, input logic [31:0] d);
    exp_t e;
    nTests++;
    if (v === 1'b1) begin
      if (expQ[p].size() == 0) begin
        nFail++;
        $display("[TB] FAIL port%0d unexpected valid at cycle %0d: data %h, required no valid", p, cyc, d);
      end else begin
        e = expQ[p].pop_front();
        if (e.due != cyc || e.data !== d) begin
          nFail++;
          $display("[TB] FAIL port%0d read: got %h at cycle %0d, required %h at cycle %0d",
                   p, d, cyc, e.data, e.due);
        end
      end
      lastData[p] = d;
    end else begin
      if (d !== lastData[p] || v !== 1'b0) begin
        nFail++;
        $display("[TB] FAIL port%0d hold: got %h valid %b, required %h valid 0", p, d, v, lastData[p]);
      end
      if (expQ[p].size() > 0 && expQ[p][0].due <= cyc) begin
        e = expQ[p].pop_front();
        nTests++;
        nFail++;
        $display("[TB] FAIL port%0d missing valid: got none at cycle %0d, required %h at cycle %0d",
                 p, cyc, e.data, e.due);
      end
    end
  endtask

  // Monitor: compares every port on every falling edge while out of reset.
  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      for (int p = 0; p < 4; p++) lastData[p] = '0;
    end else begin
      checkOutput(0, valida0, douta0);
      checkOutput(1, validb0, doutb0);
      checkOutput(2, valida1, douta1);
      checkOutput(3, validb1, doutb1);
`ifdef TDP_RAM_COLLISION_DET_EN
      checkEq("collision dut0", 32'(coll0), 32'(collExp.exists(cyc) ? collExp[cyc] : 1'b0));
      checkEq("collision dut1", 32'(coll1), 32'(collExp.exists(cyc) ? collExp[cyc] : 1'b0));
`endif
    end
  end

  // One access cycle: drive both ports and queue what each output must show.
  task automatic applyStimulus(input logic ea, input logic [3:0] wa, input logic [7:0] aa,
                               input logic [31:0] da, input logic eb, input logic [3:0] wb,
                               input logic [7:0] ab, input logic [31:0] db);
    logic [31:0] oldA, oldB;
    @(posedge clk);
    #1;
    ena = ea; wea = wa; addra = aa; dina = da;
    enb = eb; web = wb; addrb = ab; dinb = db;
    oldA = modelMem[aa];
    oldB = modelMem[ab];
    if (ea) begin
      expQ[0].push_back('{cyc + 2, oldA});
      expQ[2].push_back('{cyc + 1, laneMerge(oldA, da, wa)});
    end
    if (eb) begin
      expQ[1].push_back('{cyc + 2, oldB});
      if (wb == 4'h0) expQ[3].push_back('{cyc + 1, oldB});
    end
    collExp[cyc + 1] = ea && eb && (aa == ab) && (wa != 4'h0 || wb != 4'h0);
    for (int i = 0; i < 4; i++) begin
      if (eb && wb[i]) modelMem[ab][i*8 +: 8] = db[i*8 +: 8];
    end
    for (int i = 0; i < 4; i++) begin
      if (ea && wa[i]) modelMem[aa][i*8 +: 8] = da[i*8 +: 8];
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 4'h0, 8'h00, 32'h0, 0, 4'h0, 8'h00, 32'h0);
  endtask

  // Reset, then run the sweep for 'cycles' edges checking init_done each
  // edge. Port traffic during the sweep must be ignored.
  task automatic resetAndSweep(input int cycles);
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 1; k <= cycles; k++) begin
      if (k < 200) begin
        ena = 1'b1; wea = 4'hF; addra = 8'h00; dina = $urandom;
        enb = 1'b1; web = 4'h0; addrb = 8'($urandom); dinb = $urandom;
      end else begin
        ena = 1'b0; wea = 4'h0; enb = 1'b0; web = 4'h0;
      end
      @(posedge clk);
      #1;
      checkEq($sformatf("init_done dut0 k=%0d", k), 32'(init0), 32'(k >= D));
      checkEq($sformatf("init_done dut1 k=%0d", k), 32'(init1), 32'(k >= D));
    end
    if (cycles >= D) begin
      for (int a = 0; a < D; a++) modelMem[a] = '0;
    end
  endtask

  initial begin
    ena = 0; enb = 0; wea = 0; web = 0; addra = 0; addrb = 0; dina = 0; dinb = 0;
    for (int a = 0; a < D; a++) modelMem[a] = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1;
    checkEq("reset douta0", douta0, 32'h0);
    checkEq("reset valida0", 32'(valida0), 32'h0);
    checkEq("reset doutb1", doutb1, 32'h0);
    checkEq("reset init_done0", 32'(init0), 32'h0);

    resetAndSweep(260);

    // Cleared top word and word 0 (written during the sweep, must be dropped)
    applyStimulus(1, 4'h0, 8'hFF, 32'h0, 1, 4'h0, 8'h00, 32'h0);

    // Partial byte write
    applyStimulus(1, 4'hF, 8'h10, 32'hDEADBEEF, 0, 4'h0, 8'h00, 32'h0);
    applyStimulus(1, 4'b0101, 8'h10, 32'h11223344, 0, 4'h0, 8'h00, 32'h0);
    applyStimulus(1, 4'h0, 8'h10, 32'h0, 1, 4'h0, 8'h10, 32'h0);

    // Same-address double write, A wins
    applyStimulus(1, 4'hF, 8'h20, 32'hAAAAAAAA, 1, 4'hF, 8'h20, 32'h55555555);
    applyStimulus(1, 4'h0, 8'h20, 32'h0, 1, 4'h0, 8'h20, 32'h0);
    // Partially overlapping lanes
    applyStimulus(1, 4'b0011, 8'h21, 32'h12345678, 1, 4'b0110, 8'h21, 32'h9ABCDEF0);
    applyStimulus(1, 4'h0, 8'h21, 32'h0, 0, 4'h0, 8'h00, 32'h0);

    // Read-during-write modes on word 5
    applyStimulus(1, 4'hF, 8'h05, 32'h01020304, 0, 4'h0, 8'h00, 32'h0);
    applyStimulus(1, 4'b1000, 8'h05, 32'hFF000000, 0, 4'h0, 8'h00, 32'h0);
    applyStimulus(0, 4'h0, 8'h00, 32'h0, 1, 4'b1000, 8'h05, 32'h77000000);
    applyStimulus(1, 4'h0, 8'h05, 32'h0, 1, 4'h0, 8'h05, 32'h0);

    // Single read then idle: latency and hold
    applyStimulus(1, 4'h0, 8'h10, 32'h0, 0, 4'h0, 8'h00, 32'h0);
    idle(4);

    // Randomized traffic on a small address window to provoke collisions
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 1) ? 4'($urandom) : 4'h0,
                    8'($urandom_range(0, 15)), $urandom,
                    $urandom_range(0, 3) != 0, $urandom_range(0, 1) ? 4'($urandom) : 4'h0,
                    8'($urandom_range(0, 15)), $urandom);
    end
    idle(4);

    // Reset with non-zero outputs, then abort a sweep at count 100
    applyStimulus(1, 4'hF, 8'h03, 32'hCAFEF00D, 0, 4'h0, 8'h00, 32'h0);
    applyStimulus(1, 4'h0, 8'h03, 32'h0, 1, 4'h0, 8'h03, 32'h0);
    idle(4);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkEq("async reset douta0", douta0, 32'h0);
    checkEq("async reset doutb0", doutb0, 32'h0);
    checkEq("async reset douta1", douta1, 32'h0);
    checkEq("async reset doutb1", doutb1, 32'h0);
    checkEq("async reset init_done0", 32'(init0), 32'h0);
    resetAndSweep(100);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkEq("mid-sweep reset init_done0", 32'(init0), 32'h0);
    resetAndSweep(260);

    // Everything must read back as zero after the full sweep
    applyStimulus(1, 4'h0, 8'h03, 32'h0, 1, 4'h0, 8'h10, 32'h0);
    applyStimulus(1, 4'h0, 8'hFF, 32'h0, 1, 4'h0, 8'h05, 32'h0);
    idle(5);

    for (int p = 0; p < 4; p++) begin
      if (expQ[p].size() != 0) begin
        nTests++;
        nFail++;
        $display("[TB] FAIL port%0d drain: got %0d entries left, required 0", p, expQ[p].size());
      end
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
